freq_sel_ctrl: RTL

FREQ_SEL_CTRL -- requirements
Module: freq_sel_ctrl

---
 rtl/freq_sel_ctrl_pkg.sv | 36 +++
 rtl/freq_sel_ctrl_debounce.sv | 69 ++++++
 rtl/freq_sel_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/freq_sel_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : freq_sel_ctrl_pkg
// Description : Shared definitions for the frequency-select controller:
//               selection width and ceiling, handshake FSM encoding and the
//               saturating up/down step used on the pending selection.
// Revision    : 1.0 - initial release
// ============================================================================
package freq_sel_ctrl_pkg;

  localparam int                PROG_W   = 3;
  localparam logic [PROG_W-1:0] PROG_MAX = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ERR    = 2'd3
  } state_e;

  // Saturating step; coincident up and down leave the selection unchanged.
  function automatic logic [PROG_W-1:0] step_sel(input logic [PROG_W-1:0] sel,
                                                 input logic              up,
                                                 input logic              down);
    logic [PROG_W-1:0] nxt;
    nxt = sel;
    if (up && !down && (sel != PROG_MAX)) begin
      nxt = sel + PROG_W'(1);
    end else if (down && !up && (sel != '0)) begin
      nxt = sel - PROG_W'(1);
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/freq_sel_ctrl_debounce.sv
`default_nettype none
// ============================================================================
// Module      : freq_sel_ctrl_debounce
// Description : Push-button conditioner. Two-flop synchronizer, stability
//               counter that accepts a new level only after DEBOUNCE_CYCLES
//               consecutive equal samples, and a one-cycle pulse on each
//               rising edge of the accepted level.
// Ports       : clock   - system clock
//               reset   - asynchronous active-high reset
//               btn_raw - raw asynchronous button, active-high
//               press   - one-cycle pulse per debounced press
// Revision    : 1.0 - initial release
// ============================================================================
module freq_sel_ctrl_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int               c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               level_q, level_d;
  logic [c_cnt_w-1:0] cnt_q,   cnt_d;
  logic               press_q, press_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    // cnt_q holds how many consecutive samples already disagreed with the
    // accepted level; any agreeing sample restarts the run.
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == c_cnt_last) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + c_cnt_w'(1);
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/freq_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : freq_sel_ctrl
// Description : Front-panel controller for a programmable clock divider.
//               Up/down buttons move a pending selection, apply launches a
//               load handshake (update strobe, wait for echo with timeout).
// Ports       : clock, reset           - clock, async active-high reset
//               btn_up/down/apply      - raw push-buttons
//               prog_echo              - selection the divider has applied
//               tick_in                - divider output enable pulse
//               prog_sel               - pending selection to the divider
//               update                 - one-cycle load strobe
//               busy, done, error      - handshake status
//               active_sel             - last selection confirmed by echo
//               heartbeat              - toggles on every tick_in
// Revision    : 1.0 - initial release
// ============================================================================
module freq_sel_ctrl
  import freq_sel_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_apply,
  input  logic [PROG_W-1:0] prog_echo,
  input  logic              tick_in,
  output logic [PROG_W-1:0] prog_sel,
  output logic              update,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [PROG_W-1:0] active_sel,
  output logic              heartbeat
);

  localparam int                 c_num_btn  = 3;
  localparam int                 c_tmo_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES);

  // Button order within the vectors: 0 = up, 1 = down, 2 = apply.
  logic [c_num_btn-1:0] w_btn_raw;
  logic [c_num_btn-1:0] w_press;

  assign w_btn_raw = {btn_apply, btn_down, btn_up};

  for (genvar gi = 0; gi < c_num_btn; gi++) begin : g_btn
    freq_sel_ctrl_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock  (clock),
      .reset  (reset),
      .btn_raw(w_btn_raw[gi]),
      .press  (w_press[gi])
    );
  end

  logic w_up_p, w_down_p, w_apply_p;
  assign w_up_p    = w_press[0];
  assign w_down_p  = w_press[1];
  assign w_apply_p = w_press[2];

  state_e              state_q,  state_d;
  logic [PROG_W-1:0]   sel_q,    sel_d;
  logic [PROG_W-1:0]   active_q, active_d;
  logic [c_tmo_w-1:0]  wcnt_q,   wcnt_d;
  logic                done_q,   done_d;
  logic                hb_q,     hb_d;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    active_d = active_q;
    wcnt_d   = wcnt_q;
    done_d   = 1'b0;
    hb_d     = hb_q ^ tick_in;

    case (state_q)
      ST_IDLE: begin
        sel_d = step_sel(sel_q, w_up_p, w_down_p);
        if (w_apply_p) begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        wcnt_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A match on the final counted cycle still wins over the timeout.
        if (prog_echo == sel_q) begin
          active_d = sel_q;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else if (wcnt_q == c_tmo_last) begin
          state_d = ST_ERR;
        end else begin
          wcnt_d = wcnt_q + c_tmo_w'(1);
        end
      end
      ST_ERR: begin
        if (w_apply_p) begin
          state_d = ST_UPDATE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      active_q <= '0;
      wcnt_q   <= '0;
      done_q   <= 1'b0;
      hb_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      active_q <= active_d;
      wcnt_q   <= wcnt_d;
      done_q   <= done_d;
      hb_q     <= hb_d;
    end
  end

  // Status is decoded from the state register so reset removes it at once.
  assign update     = (state_q == ST_UPDATE);
  assign busy       = (state_q == ST_UPDATE) || (state_q == ST_WAIT);
  assign error      = (state_q == ST_ERR);
  assign done       = done_q;
  assign prog_sel   = sel_q;
  assign active_sel = active_q;
  assign heartbeat  = hb_q;

endmodule
`default_nettype wire
